// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/store unit: funct3 encodings, exception codes
// and the bus-master FSM states.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct3[1:0] encodes access size for both loads and stores.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef enum logic [1:0] {
        ExcNone          = 2'd0,
        ExcLoadMisalign  = 2'd1,
        ExcStoreMisalign = 2'd2,
        ExcBusTimeout    = 2'd3
    } lsu_exc_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = offset[0];
            default:   mis = |offset;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_wb_master_if.sv
// Wishbone pipelined data-port bundle between the LSU (master) and main memory (slave).
interface lsu_wb_master_if;

    logic        cyc;
    logic        stb;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_sel;
    logic        ack;
    logic        stall;
    logic [31:0] rd_data;

    modport master (
        output cyc, stb, wr_en, addr, wr_data, wr_sel,
        input  ack, stall, rd_data
    );

    modport slave (
        input  cyc, stb, wr_en, addr, wr_data, wr_sel,
        output ack, stall, rd_data
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/replication and load extract/extend.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  wr_sel,
    output logic [31:0] wr_data,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        wr_sel  = 4'b1111;
        wr_data = 32'd0;
        if (is_store) begin
            case (funct3[1:0])
                SIZE_BYTE: begin
                    wr_sel  = 4'b0001 << offset;
                    wr_data = {4{st_data[7:0]}};
                end
                SIZE_HALF: begin
                    wr_sel  = offset[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{st_data[15:0]}};
                end
                default: wr_data = st_data;
            endcase
        end
    end

    // Bring the addressed byte/half down to bit 0; words are aligned so the shift is zero.
    assign shifted = ld_raw >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_LB:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  ld_data = {24'd0, shifted[7:0]};
            F3_LHU:  ld_data = {16'd0, shifted[15:0]};
            F3_LW:   ld_data = shifted;
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_wb_master.sv
// Memory-access stage: turns loads/stores into single Wishbone pipelined cycles, stalls
// upstream until completion and passes non-memory results straight through.
module lsu_wb_master
    import rv32i_pkg::*;
#(
    parameter int unsigned WB_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            execute_is_load,
    input  logic            execute_is_store,
    input  logic [2:0]      execute_funct3,
    input  logic [31:0]     execute_result,
    input  logic [31:0]     execute_rs2_data,
    input  logic [4:0]      execute_rd,
    input  logic            execute_rd_wr_en,
    input  logic            flush,
    lsu_wb_master_if.master wb,
    output logic [4:0]      memory_rd,
    output logic            memory_rd_wr_en,
    output logic [31:0]     memory_rd_wr_data,
    output logic [1:0]      memory_exception,
    output logic            next_clk_en,
    output logic            next_stall
);

    localparam int unsigned CntW = $clog2(WB_TIMEOUT + 1);

    lsu_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            kill_q, kill_d;
    logic [31:0]     addr_q;
    logic [2:0]      funct3_q;
    logic            store_q;
    logic [31:0]     data_q;
    logic [4:0]      rd_q;
    logic            rd_wr_en_q;

    logic        is_mem;
    logic        misaligned;
    logic        accept;
    logic        finish;
    logic        timeout;
    logic        bus_active;
    logic [3:0]  sel;
    logic [31:0] wr_data;
    logic [31:0] ld_data;

    assign is_mem     = execute_is_load | execute_is_store;
    assign misaligned = is_misaligned(execute_funct3[1:0], execute_result[1:0]);
    assign bus_active = (state_q == StReq) || (state_q == StWait);

    lsu_align u_align (
        .funct3   (funct3_q),
        .offset   (addr_q[1:0]),
        .is_store (store_q),
        .st_data  (data_q),
        .ld_raw   (wb.rd_data),
        .wr_sel   (sel),
        .wr_data  (wr_data),
        .ld_data  (ld_data)
    );

    // Bus outputs come only from registers captured at accept, so they hold through stalls.
    assign wb.cyc     = bus_active;
    assign wb.stb     = (state_q == StReq);
    assign wb.wr_en   = bus_active & store_q;
    assign wb.addr    = bus_active ? {addr_q[31:2], 2'b00} : 32'd0;
    assign wb.wr_sel  = bus_active ? sel : 4'd0;
    assign wb.wr_data = bus_active ? wr_data : 32'd0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kill_d     = kill_q;
        accept     = 1'b0;
        finish     = 1'b0;
        timeout    = 1'b0;
        next_stall = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d  = '0;
                kill_d = 1'b0;
                if (clk_en && is_mem && !misaligned && !flush) begin
                    accept     = 1'b1;
                    next_stall = 1'b1;
                    state_d    = StReq;
                end
            end
            StReq: begin
                next_stall = 1'b1;
                kill_d     = kill_q | flush;
                if (!wb.stall) begin
                    if (wb.ack) begin
                        finish  = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                next_stall = 1'b1;
                kill_d     = kill_q | flush;
                cnt_d      = cnt_q + CntW'(1);
                if (wb.ack) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end else if (cnt_d == CntW'(WB_TIMEOUT)) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            kill_q            <= 1'b0;
            addr_q            <= 32'd0;
            funct3_q          <= 3'd0;
            store_q           <= 1'b0;
            data_q            <= 32'd0;
            rd_q              <= 5'd0;
            rd_wr_en_q        <= 1'b0;
            memory_rd         <= 5'd0;
            memory_rd_wr_en   <= 1'b0;
            memory_rd_wr_data <= 32'd0;
            memory_exception  <= ExcNone;
            next_clk_en       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            next_clk_en <= 1'b0;
            if (accept) begin
                addr_q     <= execute_result;
                funct3_q   <= execute_funct3;
                store_q    <= ~execute_is_load;
                data_q     <= execute_rs2_data;
                rd_q       <= execute_rd;
                rd_wr_en_q <= execute_rd_wr_en;
            end
            // Single-cycle results: non-memory pass-through or misaligned access trap.
            if (state_q == StIdle && clk_en && !flush && !accept) begin
                next_clk_en <= 1'b1;
                memory_rd   <= execute_rd;
                if (is_mem) begin
                    memory_rd_wr_en   <= 1'b0;
                    memory_rd_wr_data <= 32'd0;
                    memory_exception  <= execute_is_load ? ExcLoadMisalign : ExcStoreMisalign;
                end else begin
                    memory_rd_wr_en   <= execute_rd_wr_en;
                    memory_rd_wr_data <= execute_result;
                    memory_exception  <= ExcNone;
                end
            end
            if (finish && !kill_d) begin
                next_clk_en       <= 1'b1;
                memory_rd         <= rd_q;
                memory_rd_wr_en   <= rd_wr_en_q & ~store_q & ~timeout;
                memory_rd_wr_data <= (store_q || timeout) ? 32'd0 : ld_data;
                memory_exception  <= timeout ? ExcBusTimeout : ExcNone;
            end
        end
    end

endmodule

// File: tb/tb_lsu_wb_master.sv
// Directed plus random bench for lsu_wb_master; the bench plays the Wishbone slave.
module tb_lsu_wb_master;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        e_load;
    logic        e_store;
    logic [2:0]  e_f3;
    logic [31:0] e_result;
    logic [31:0] e_rs2;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic        flush;
    logic [4:0]  memory_rd;
    logic        memory_rd_wr_en;
    logic [31:0] memory_rd_wr_data;
    logic [1:0]  memory_exception;
    logic        next_clk_en;
    logic        next_stall;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_errors = 0;

    lsu_wb_master_if wb_bus ();

    lsu_wb_master #(
        .WB_TIMEOUT (TIMEOUT)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .clk_en            (clk_en),
        .execute_is_load   (e_load),
        .execute_is_store  (e_store),
        .execute_funct3    (e_f3),
        .execute_result    (e_result),
        .execute_rs2_data  (e_rs2),
        .execute_rd        (e_rd),
        .execute_rd_wr_en  (e_wen),
        .flush             (flush),
        .wb                (wb_bus),
        .memory_rd         (memory_rd),
        .memory_rd_wr_en   (memory_rd_wr_en),
        .memory_rd_wr_data (memory_rd_wr_data),
        .memory_exception  (memory_exception),
        .next_clk_en       (next_clk_en),
        .next_stall        (next_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the stage idle again.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd,
                          input logic wen, input int n_stall, input int ack_lat,
                          input logic no_ack, input logic flush_wait);
        int          size, off, exp_wait, req_n, wait_n;
        logic        mem_op, mis, fin, stl, ak;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata, exp_ld, lmask;
        logic [1:0]  exp_exc;
        logic        exp_wen;
        logic [7:0]  idx;

        mem_op = ld | st;
        size   = 1 << int'(f3[1:0]);
        off    = int'(a[1:0]);
        mis    = mem_op && ((off % size) != 0);
        idx    = a[9:2];
        exp_sel = st ? 4'(((1 << size) - 1) << off) : 4'b1111;
        if (size == 1)      exp_wdata = {24'd0, rs2[7:0]} * 32'h0101_0101;
        else if (size == 2) exp_wdata = {16'd0, rs2[15:0]} * 32'h0001_0001;
        else                exp_wdata = rs2;
        lmask  = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        exp_ld = (mem[idx] >> (8 * off)) & lmask;
        if (!f3[2] && size < 4 && exp_ld[8 * size - 1]) exp_ld = exp_ld | ~lmask;
        if (!mem_op) exp_ld = a;
        exp_exc  = mis ? (ld ? 2'd1 : 2'd2) : ((mem_op && no_ack) ? 2'd3 : 2'd0);
        exp_wen  = !st && wen && !mis && !(mem_op && no_ack);
        exp_wait = no_ack ? int'(TIMEOUT) : ack_lat;

        clk_en = 1'b1; e_load = ld; e_store = st; e_f3 = f3; e_result = a;
        e_rs2 = rs2; e_rd = rd; e_wen = wen; flush = 1'b0;
        wb_bus.ack = 1'b0; wb_bus.stall = 1'b0;
        #2;
        check("idle_stall", 32'(next_stall), 32'(mem_op && !mis));
        check("idle_cyc", 32'(wb_bus.cyc), 32'd0);

        if (!mem_op || mis) begin
            @(posedge clk); #1;
            clk_en = 1'b0;
            @(negedge clk);
            check("one_nce", 32'(next_clk_en), 32'd1);
            check("one_exc", 32'(memory_exception), 32'(exp_exc));
            check("one_wen", 32'(memory_rd_wr_en), 32'(exp_wen));
            check("one_cyc", 32'(wb_bus.cyc), 32'd0);
            if (!mem_op) begin
                check("one_rd", 32'(memory_rd), 32'(rd));
                check("one_data", memory_rd_wr_data, exp_ld);
            end
        end else begin
            req_n = 0; wait_n = 0; fin = 1'b0;
            for (int c = 0; c < 64 && !fin; c++) begin
                @(posedge clk); #1;
                wb_bus.ack = 1'b0; flush = 1'b0;
                wb_bus.rd_data = mem[idx];
                if (wb_bus.cyc && wb_bus.stb) begin
                    stl = (req_n < n_stall);
                    ak  = !stl && ack_lat == 0 && !no_ack;
                    wb_bus.stall = stl; wb_bus.ack = ak;
                    @(negedge clk);
                    check("req_addr", wb_bus.addr, {a[31:2], 2'b00});
                    check("req_sel", 32'(wb_bus.wr_sel), 32'(exp_sel));
                    check("req_we", 32'(wb_bus.wr_en), 32'(st));
                    check("req_stall", 32'(next_stall), 32'd1);
                    if (st) check("req_wdata", wb_bus.wr_data, exp_wdata);
                    req_n++;
                end else if (wb_bus.cyc) begin
                    wb_bus.stall = 1'b0;
                    wait_n++;
                    ak = !no_ack && (wait_n >= ack_lat);
                    wb_bus.ack = ak;
                    flush = flush_wait && wait_n == 1;
                    @(negedge clk);
                    check("wait_stb", 32'(wb_bus.stb), 32'd0);
                    check("wait_stall", 32'(next_stall), 32'd1);
                end else begin
                    ak  = 1'b0;
                    fin = 1'b1;
                    wb_bus.stall = 1'b0;
                    @(negedge clk);
                    check("done_nce", 32'(next_clk_en), 32'(!flush_wait));
                    check("done_stall", 32'(next_stall), 32'd0);
                    if (!flush_wait) begin
                        check("done_exc", 32'(memory_exception), 32'(exp_exc));
                        check("done_wen", 32'(memory_rd_wr_en), 32'(exp_wen));
                        if (ld && !no_ack) begin
                            check("done_rd", 32'(memory_rd), 32'(rd));
                            check("done_data", memory_rd_wr_data, exp_ld);
                        end
                    end
                end
                if (ak && st) begin
                    for (int b = 0; b < 4; b++)
                        if (exp_sel[b]) mem[idx][8*b +: 8] = exp_wdata[8*b +: 8];
                end
            end
            check("reached_done", 32'(fin), 32'd1);
            check("req_cycles", 32'(req_n), 32'(n_stall + 1));
            check("wait_cycles", 32'(wait_n), 32'(exp_wait));
        end

        @(posedge clk); #1;
        clk_en = 1'b0; flush = 1'b0; wb_bus.ack = 1'b0;
        @(negedge clk);
        check("nce_once", 32'(next_clk_en), 32'd0);
        check("idle_after", 32'(wb_bus.cyc), 32'd0);
    endtask

    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];

    initial begin
        int kind, stl_n, lat;
        logic fw;

        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};
        rst_n = 1'b0; clk_en = 1'b0; e_load = 1'b0; e_store = 1'b0; e_f3 = 3'd0;
        e_result = 32'd0; e_rs2 = 32'd0; e_rd = 5'd0; e_wen = 1'b0; flush = 1'b0;
        wb_bus.ack = 1'b0; wb_bus.stall = 1'b0; wb_bus.rd_data = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        #12;
        check("rst_cyc", 32'(wb_bus.cyc), 32'd0);
        check("rst_stb", 32'(wb_bus.stb), 32'd0);
        check("rst_nce", 32'(next_clk_en), 32'd0);
        check("rst_stall", 32'(next_stall), 32'd0);
        check("rst_exc", 32'(memory_exception), 32'd0);
        check("rst_wdata", memory_rd_wr_data, 32'd0);
        check("rst_addr", wb_bus.addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stores: SW zero-wait, SB to the top lane.
        run_op(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, 0, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 3'b000, 32'h103, 32'h1234_56A5, 5'd0, 1'b0, 1, 1, 1'b0, 1'b0);

        // Loads from 0x80FF7F01.
        mem[8'h40] = 32'h80FF_7F01;
        run_op(1'b1, 1'b0, 3'b000, 32'h102, 32'd0, 5'd1, 1'b1, 0, 0, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 5'd2, 1'b1, 1, 2, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 5'd3, 1'b1, 0, 1, 1'b0, 1'b0);
        run_op(1'b1, 1'b0, 3'b101, 32'h100, 32'd0, 5'd4, 1'b1, 2, 0, 1'b0, 1'b0);

        // LW held by wb_stall for 3 cycles.
        run_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 1'b1, 3, 2, 1'b0, 1'b0);

        // Misaligned accesses never touch the bus.
        run_op(1'b1, 1'b0, 3'b010, 32'h102, 32'd0, 5'd6, 1'b1, 0, 0, 1'b0, 1'b0);
        run_op(1'b0, 1'b1, 3'b001, 32'h101, 32'h55AA, 5'd0, 1'b0, 0, 0, 1'b0, 1'b0);

        // Bus timeout, then flush during WAIT.
        run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 5'd7, 1'b1, 1, 0, 1'b1, 1'b0);
        run_op(1'b1, 1'b0, 3'b010, 32'h108, 32'd0, 5'd8, 1'b1, 0, 2, 1'b0, 1'b1);

        // Non-memory pass-through.
        run_op(1'b0, 1'b0, 3'b000, 32'hCAFE_F00D, 32'd0, 5'd9, 1'b1, 0, 0, 1'b0, 1'b0);

        // Flush in IDLE drops the instruction.
        clk_en = 1'b1; e_load = 1'b1; e_f3 = 3'b010; e_result = 32'h10C; flush = 1'b1;
        #2;
        check("fl_idle_stall", 32'(next_stall), 32'd0);
        @(posedge clk); #1;
        clk_en = 1'b0; e_load = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("fl_idle_cyc", 32'(wb_bus.cyc), 32'd0);
        check("fl_idle_nce", 32'(next_clk_en), 32'd0);

        // Stray ack while idle.
        wb_bus.ack = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("stray_cyc", 32'(wb_bus.cyc), 32'd0);
        check("stray_nce", 32'(next_clk_en), 32'd0);
        wb_bus.ack = 1'b0;

        // Random mix against the reference model.
        for (int i = 0; i < 40; i++) begin
            kind  = int'($urandom_range(0, 2));
            stl_n = int'($urandom_range(0, 3));
            lat   = int'($urandom_range(0, 3));
            fw    = (lat > 0) && ($urandom_range(0, 7) == 0);
            if (kind == 0)
                run_op(1'b1, 1'b0, ld_f3[$urandom_range(0, 4)], 32'h100 + $urandom_range(0, 63),
                       32'd0, 5'($urandom), 1'($urandom), stl_n, lat, 1'b0, fw);
            else if (kind == 1)
                run_op(1'b0, 1'b1, st_f3[$urandom_range(0, 2)], 32'h100 + $urandom_range(0, 63),
                       $urandom, 5'd0, 1'b0, stl_n, lat, 1'b0, fw);
            else
                run_op(1'b0, 1'b0, 3'($urandom), $urandom, 32'd0, 5'($urandom), 1'($urandom),
                       0, 0, 1'b0, 1'b0);
        end

        // Asynchronous reset while a request is being stalled.
        clk_en = 1'b1; e_load = 1'b1; e_store = 1'b0; e_f3 = 3'b010; e_result = 32'h110;
        e_wen = 1'b1; wb_bus.stall = 1'b1;
        @(posedge clk); #1;
        check("ar_cyc_before", 32'(wb_bus.cyc), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_cyc", 32'(wb_bus.cyc), 32'd0);
        check("ar_stb", 32'(wb_bus.stb), 32'd0);
        clk_en = 1'b0; e_load = 1'b0; wb_bus.stall = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_after_nce", 32'(next_clk_en), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
